// File: rtl/init_reset_sequencer.sv
// Reset-release sequencer fed by the init monitor and fabric PLL lock.
// Releases fabric reset after a stable-lock delay, then CPU reset after DDR calibration or timeout.
module init_reset_sequencer #(
  parameter int unsigned SYNC_STAGES          = 2,
  parameter int unsigned RELEASE_DELAY        = 16,
  parameter int unsigned CALIB_TIMEOUT_CYCLES = 1048576,
  parameter bit          CALIB_REQUIRED       = 1'b1
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       DEVICE_INIT_DONE,
  input  logic       SRAM_INIT_DONE,
  input  logic       AUTOCALIB_DONE,
  input  logic       PLL_LOCK,
  output logic       FABRIC_RESET_N,
  output logic       CPU_RESET_N,
  output logic       CALIB_TIMEOUT,
  output logic [2:0] SEQ_STATE
);

  localparam int unsigned CNT_RANGE = (RELEASE_DELAY > CALIB_TIMEOUT_CYCLES) ?
                                      RELEASE_DELAY : CALIB_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_RANGE + 1);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_DELAY     = 3'd2;
  localparam logic [2:0] S_FABRIC    = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end
  if (RELEASE_DELAY < 2) begin : g_bad_delay
    $error("RELEASE_DELAY must be at least 2");
  end

  logic [3:0]       sync_q [SYNC_STAGES];
  logic             device_init_done_s;
  logic             sram_init_done_s;
  logic             autocalib_done_s;
  logic             pll_lock_s;
  logic [2:0]       state;
  logic [2:0]       state_next;
  logic             timeout_hit_c;
  logic [CNT_W-1:0] cnt;

  // Multi-flop synchronisers; nothing downstream sees the raw inputs.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {DEVICE_INIT_DONE, SRAM_INIT_DONE, AUTOCALIB_DONE, PLL_LOCK};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {device_init_done_s, sram_init_done_s, autocalib_done_s, pll_lock_s} =
    sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (!RESETN) state <= S_WAIT_INIT;
    else         state <= state_next;
  end

  // Lock loss beats every forward transition; a calibration-done beats the timeout.
  always_comb begin
    state_next    = state;
    timeout_hit_c = 1'b0;
    case (state)
      S_WAIT_INIT: if (device_init_done_s && sram_init_done_s) state_next = S_WAIT_LOCK;
      S_WAIT_LOCK: if (pll_lock_s) state_next = S_DELAY;
      S_DELAY: begin
        if (!pll_lock_s)              state_next = S_WAIT_LOCK;
        else if (cnt == DELAY_LAST)   state_next = S_FABRIC;
      end
      S_FABRIC: begin
        if (!pll_lock_s) begin
          state_next = S_WAIT_LOCK;
        end else if (!CALIB_REQUIRED || autocalib_done_s) begin
          state_next = S_RUN;
        end else if (cnt == CALIB_LAST) begin
          state_next    = S_RUN;
          timeout_hit_c = 1'b1;
        end
      end
      S_RUN:   if (!pll_lock_s) state_next = S_WAIT_LOCK;
      default: state_next = S_WAIT_INIT;
    endcase
  end

  // Shared dwell counter: restarts on every state change, saturates rather than wraps.
  always_ff @(posedge CLK) begin
    if (!RESETN || (state_next != state)) cnt <= '0;
    else if (cnt != CNT_SAT)              cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      FABRIC_RESET_N <= 1'b0;
      CPU_RESET_N    <= 1'b0;
      CALIB_TIMEOUT  <= 1'b0;
    end else begin
      FABRIC_RESET_N <= (state_next == S_FABRIC) || (state_next == S_RUN);
      CPU_RESET_N    <= (state_next == S_RUN);
      if (timeout_hit_c) CALIB_TIMEOUT <= 1'b1;
    end
  end

  assign SEQ_STATE = state;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Bench for init_reset_sequencer: directed vector table, corner sequences and random
// stimulus checked every cycle against a lock-run-length reference model.
module tb_init_reset_sequencer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned RD   = 16;
  localparam int unsigned CT   = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       dev = 1'b0, sram = 1'b0, cal = 1'b0, lock = 1'b0;
  logic       frn0, crn0, to0, frn1, crn1, to1;
  logic [2:0] st0, st1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  init_reset_sequencer #(.SYNC_STAGES(SYNC), .RELEASE_DELAY(RD),
                         .CALIB_TIMEOUT_CYCLES(CT), .CALIB_REQUIRED(1'b1)) u_dut (
    .CLK(clk), .RESETN(rstn), .DEVICE_INIT_DONE(dev), .SRAM_INIT_DONE(sram),
    .AUTOCALIB_DONE(cal), .PLL_LOCK(lock), .FABRIC_RESET_N(frn0),
    .CPU_RESET_N(crn0), .CALIB_TIMEOUT(to0), .SEQ_STATE(st0));

  init_reset_sequencer #(.SYNC_STAGES(SYNC), .RELEASE_DELAY(RD),
                         .CALIB_TIMEOUT_CYCLES(CT), .CALIB_REQUIRED(1'b0)) u_dut_nocal (
    .CLK(clk), .RESETN(rstn), .DEVICE_INIT_DONE(dev), .SRAM_INIT_DONE(sram),
    .AUTOCALIB_DONE(cal), .PLL_LOCK(lock), .FABRIC_RESET_N(frn1),
    .CPU_RESET_N(crn1), .CALIB_TIMEOUT(to1), .SEQ_STATE(st1));

  // Reference model: inputs seen SYNC edges late; progress measured as consecutive locked edges.
  bit [3:0] pipe [SYNC];
  bit       m_init [2];
  int       m_run  [2];
  bit       m_cpu  [2];
  bit       m_to   [2];

  function automatic void model_update();
    bit [3:0] seen;
    bit       req;
    if (!rstn) begin
      for (int i = 0; i < int'(SYNC); i++) pipe[i] = '0;
      for (int k = 0; k < 2; k++) begin
        m_init[k] = 0; m_run[k] = 0; m_cpu[k] = 0; m_to[k] = 0;
      end
      return;
    end
    seen = pipe[SYNC-1];
    for (int k = 0; k < 2; k++) begin
      req = (k == 0);
      if (!m_init[k]) begin
        if (seen[3] && seen[2]) m_init[k] = 1;
      end else if (!seen[0]) begin
        m_run[k] = 0;
        m_cpu[k] = 0;
      end else begin
        if (m_run[k] < 1000) m_run[k]++;
        if (m_run[k] >= int'(RD) + 2 && !m_cpu[k]) begin
          if (seen[1] || !req) m_cpu[k] = 1;
          else if (m_run[k] == int'(RD + CT) + 1) begin
            m_cpu[k] = 1;
            m_to[k]  = 1;
          end
        end
      end
    end
    for (int i = int'(SYNC) - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = {dev, sram, cal, lock};
  endfunction

  function automatic logic [5:0] model_out(int k);
    logic [2:0] s;
    if (!m_init[k])                s = 3'd0;
    else if (m_run[k] == 0)        s = 3'd1;
    else if (m_run[k] <= int'(RD)) s = 3'd2;
    else if (!m_cpu[k])            s = 3'd3;
    else                           s = 3'd4;
    return {s, (m_init[k] && m_run[k] > int'(RD)), m_cpu[k], m_to[k]};
  endfunction

  function automatic void check_model();
    logic [5:0] got [2];
    logic [5:0] exp;
    got[0] = {st0, frn0, crn0, to0};
    got[1] = {st1, frn1, crn1, to1};
    for (int k = 0; k < 2; k++) begin
      exp = model_out(k);
      checks++;
      if (got[k] !== exp) begin
        errors++;
        $display("FAIL model[%0d] t=%0t got st=%0d frn=%b crn=%b to=%b exp st=%0d frn=%b crn=%b to=%b",
                 k, $time, got[k][5:3], got[k][2], got[k][1], got[k][0],
                 exp[5:3], exp[2], exp[1], exp[0]);
      end
      checks++;
      if (got[k][1] === 1'b1 && got[k][2] !== 1'b1) begin
        errors++;
        $display("FAIL invariant[%0d] t=%0t cpu_reset_n=%b fabric_reset_n=%b", k, $time,
                 got[k][1], got[k][2]);
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic expect_bit(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 0; dev = 0; sram = 0; cal = 0; lock = 0;
    step(); step();
    rstn = 1;
  endtask

  typedef struct {
    bit         rstn, dev, sram, cal, lock;
    int         cyc;
    logic [2:0] st;
    bit         frn, crn, to;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit d, bit s, bit c, bit l, int n,
                              logic [2:0] st, bit f, bit cp, bit t);
    vec_t v;
    v.rstn = r; v.dev = d; v.sram = s; v.cal = c; v.lock = l; v.cyc = n;
    v.st = st; v.frn = f; v.crn = cp; v.to = t;
    tbl.push_back(v);
  endfunction

  initial begin
    int n;
    logic [5:0] got, exp;
    @(negedge clk);

    // rstn dev sram cal lock cycles | state frn crn to
    add(0,0,0,0,0,  2,  0,0,0,0);   // reset state
    add(1,1,1,0,0,  3,  1,0,0,0);   // init seen after sync latency
    add(1,1,1,0,1,  2,  1,0,0,0);   // lock still in synchroniser
    add(1,1,1,0,1,  1,  2,0,0,0);   // enter delay
    add(1,1,1,0,1, 15,  2,0,0,0);   // last delay cycle
    add(1,1,1,0,1,  1,  3,1,0,0);   // fabric released after RD cycles
    add(1,1,1,1,1,  2,  3,1,0,0);   // calib done in synchroniser
    add(1,1,1,1,1,  1,  4,1,1,0);   // cpu released
    add(1,1,1,1,0,  2,  4,1,1,0);   // lock loss not yet seen
    add(1,1,1,1,0,  1,  1,0,0,0);   // both resets drop together
    add(1,1,1,0,1,  3,  2,0,0,0);   // re-sequence
    add(1,1,1,0,1, 16,  3,1,0,0);
    add(1,1,1,0,1, 63,  3,1,0,0);   // one short of timeout
    add(1,1,1,0,1,  1,  4,1,1,1);   // timeout: flag and cpu release same edge
    add(1,1,1,0,0,  3,  1,0,0,1);   // flag survives lock loss
    add(1,1,1,0,1,  3,  2,0,0,1);
    add(1,1,1,0,1, 16,  3,1,0,1);
    add(0,1,1,0,1,  1,  0,0,0,0);   // reset mid-fabric
    add(1,0,1,0,1,  5,  0,0,0,0);   // stalls without both init inputs
    add(1,1,1,0,1,  2,  0,0,0,0);
    add(1,1,1,0,1,  1,  1,0,0,0);
    add(1,1,1,0,1,  1,  2,0,0,0);

    foreach (tbl[i]) begin
      rstn = tbl[i].rstn; dev = tbl[i].dev; sram = tbl[i].sram;
      cal  = tbl[i].cal;  lock = tbl[i].lock;
      repeat (tbl[i].cyc) step();
      got = {st0, frn0, crn0, to0};
      exp = {tbl[i].st, tbl[i].frn, tbl[i].crn, tbl[i].to};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d got st=%0d frn=%b crn=%b to=%b exp st=%0d frn=%b crn=%b to=%b",
                 i, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
      end
    end

    // Lock glitch at count 10 in delay: full RD stable cycles needed afterwards.
    do_reset();
    dev = 1; sram = 1; lock = 1;
    n = 0;
    while (st0 !== 3'd2 && n < 20) begin step(); n++; end
    expect_bit("glitch_reach_delay", st0 == 3'd2, 1'b1);
    repeat (10) step();
    lock = 0;
    repeat (3) step();
    expect_bit("glitch_back_to_wait_lock", st0 == 3'd1, 1'b1);
    expect_bit("glitch_fabric_held", frn0, 1'b0);
    lock = 1;
    n = 0;
    while (frn0 !== 1'b1 && n < 60) begin step(); n++; end
    checks++;
    if (n != int'(RD) + 3) begin
      errors++;
      $display("FAIL glitch_release_latency got=%0d exp=%0d", n, RD + 3);
    end

    // Calibration not required: cpu follows fabric by exactly one cycle.
    do_reset();
    dev = 1; sram = 1; lock = 1; cal = 0;
    n = 0;
    while (frn1 !== 1'b1 && n < 40) begin step(); n++; end
    expect_bit("nocal_fabric_up", frn1, 1'b1);
    expect_bit("nocal_cpu_not_yet", crn1, 1'b0);
    step();
    expect_bit("nocal_cpu_up", crn1, 1'b1);
    expect_bit("nocal_no_timeout", to1, 1'b0);

    // Random stimulus with long lock-high stretches.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rstn = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 39) == 0) dev  = ~dev;
      if ($urandom_range(0, 39) == 0) sram = ~sram;
      if ($urandom_range(0, 49) == 0) cal  = ~cal;
      if (lock) begin
        if ($urandom_range(0, 149) == 0) lock = 0;
      end else if ($urandom_range(0, 7) == 0) lock = 1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
